// File: rtl/gate_board_renderer.sv
// Redraws the 9-tile gate board through the VGA adapter whenever the gate state changes.
// Optional build macro GATE_RENDER_BORDER_EN draws a black 1-pixel border round each tile.
module gate_board_renderer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] selected_gate,
    input  logic [8:0] completed_gate,
    input  logic [7:0] current_gate,
    input  logic       vga_blankout,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  px_q, px_d;
    logic [3:0]  py_q, py_d;
    logic [3:0]  t_q, t_d;
    logic [25:0] snap_q, snap_d;
    logic        dirty_q, dirty_d;
    logic [7:0]  x_q;
    logic [6:0]  y_q;
    logic [2:0]  colour_q;

    logic [25:0] inputs_now;
    logic [7:0]  snap_sel;
    logic [8:0]  snap_comp;
    logic [7:0]  snap_cur;
    logic        snap_blank;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic [2:0]  tile_colour;
    logic [2:0]  pix_colour;

    assign inputs_now = {selected_gate, completed_gate, current_gate, vga_blankout};
    assign snap_sel   = snap_q[25:18];
    assign snap_comp  = snap_q[17:9];
    assign snap_cur   = snap_q[8:1];
    assign snap_blank = snap_q[0];

    // x = 4 + 17*t + px, with 17*t built as 16*t + t
    assign pix_x = 8'd4 + {t_q, 4'b0000} + {4'b0000, t_q} + {4'b0000, px_q};
    assign pix_y = 7'd52 + {3'b000, py_q};

    always_comb begin
        tile_colour = 3'b111;
        if (snap_blank) begin
            tile_colour = 3'b000;
        end else if (t_q < 4'd8 && snap_sel[t_q[2:0]]) begin
            tile_colour = 3'b110;
        end else if (t_q < 4'd9 && snap_comp[t_q]) begin
            tile_colour = 3'b010;
        end else if (t_q < 4'd8 && snap_cur[t_q[2:0]]) begin
            tile_colour = 3'b001;
        end
    end

`ifdef GATE_RENDER_BORDER_EN
    always_comb begin
        pix_colour = tile_colour;
        if (px_q == 4'd0 || px_q == 4'd15 || py_q == 4'd0 || py_q == 4'd15) begin
            pix_colour = 3'b000;
        end
    end
`else
    assign pix_colour = tile_colour;
`endif

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        t_d     = t_q;
        snap_d  = snap_q;
        dirty_d = dirty_q;
        unique case (state_q)
            StIdle: begin
                if (dirty_q || inputs_now != snap_q) begin
                    state_d = StDraw;
                    snap_d  = inputs_now;
                    dirty_d = 1'b0;
                    px_d    = 4'd0;
                    py_d    = 4'd0;
                    t_d     = 4'd0;
                end
            end
            StDraw: begin
                px_d = px_q + 4'd1;
                if (px_q == 4'd15) begin
                    py_d = py_q + 4'd1;
                    if (py_q == 4'd15) begin
                        if (t_q == 4'd8) begin
                            t_d     = 4'd0;
                            state_d = StDone;
                        end else begin
                            t_d = t_q + 4'd1;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            px_q     <= 4'd0;
            py_q     <= 4'd0;
            t_q      <= 4'd0;
            snap_q   <= 26'd0;
            dirty_q  <= 1'b1;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'b000;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            t_q     <= t_d;
            snap_q  <= snap_d;
            dirty_q <= dirty_d;
            // Remember the last plotted pixel so the outputs hold outside DRAW
            if (state_q == StDraw) begin
                x_q      <= pix_x;
                y_q      <= pix_y;
                colour_q <= pix_colour;
            end
        end
    end

    always_comb begin
        plot       = (state_q == StDraw);
        busy       = (state_q != StIdle);
        frame_done = (state_q == StDone);
        x          = x_q;
        y          = y_q;
        colour     = colour_q;
        if (state_q == StDraw) begin
            x      = pix_x;
            y      = pix_y;
            colour = pix_colour;
        end
    end

endmodule

// File: tb/tb_gate_board_renderer.sv
// Directed self-checking bench for gate_board_renderer: captures whole frames and
// compares coordinates, colours and handshake timing against hand-computed tile colours.
module tb_gate_board_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] selected_gate;
    logic [8:0] completed_gate;
    logic [7:0] current_gate;
    logic       vga_blankout;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       frame_done;

    int total = 0;
    int bad = 0;
    logic [2:0] exp_tile [0:8];
    int change_at = -1;
    int abort_at = -1;

    gate_board_renderer dut (
        .clk            (clk),
        .reset          (reset),
        .selected_gate  (selected_gate),
        .completed_gate (completed_gate),
        .current_gate   (current_gate),
        .vga_blankout   (vga_blankout),
        .x              (x),
        .y              (y),
        .colour         (colour),
        .plot           (plot),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_tiles(input logic [2:0] c);
        for (int k = 0; k < 9; k++) exp_tile[k] = c;
    endtask

    // Called just after a falling edge; the first plot is expected one cycle later.
    task automatic run_frame(input string tag);
        int lat;
        int plot_err;
        int coord_err;
        int col_err;
        int t;
        int py;
        int px;
        logic [2:0] ec;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (plot !== 1'b1 && lat < 8);
        check({tag, ".latency"}, lat, 1);
        if (plot !== 1'b1) return;
        plot_err = 0;
        coord_err = 0;
        col_err = 0;
        for (int i = 0; i < 2304; i++) begin
            if (i > 0) @(negedge clk);
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                check({tag, ".abort_plot"}, plot, 0);
                return;
            end
            t = i / 256;
            py = (i / 16) % 16;
            px = i % 16;
            if (plot !== 1'b1 || busy !== 1'b1 || frame_done !== 1'b0) plot_err++;
            if (x !== 8'(4 + 17 * t + px) || y !== 7'(52 + py)) coord_err++;
            ec = exp_tile[t];
`ifdef GATE_RENDER_BORDER_EN
            if (px == 0 || px == 15 || py == 0 || py == 15) ec = 3'b000;
`endif
            if (colour !== ec) col_err++;
            if (i == change_at) current_gate = 8'h10;
        end
        check({tag, ".plot_errs"}, plot_err, 0);
        check({tag, ".coord_errs"}, coord_err, 0);
        check({tag, ".colour_errs"}, col_err, 0);
        @(negedge clk);
        check({tag, ".done_pulse"}, {plot, busy, frame_done}, 3'b011);
        check({tag, ".hold_xy"}, {x, 1'b0, y}, {8'd155, 1'b0, 7'd67});
        @(negedge clk);
        check({tag, ".idle"}, {plot, busy, frame_done}, 3'b000);
    endtask

    task automatic idle_quiet(input string tag);
        int plots;
        plots = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (plot === 1'b1) plots++;
        end
        check({tag, ".no_redraw"}, plots, 0);
    endtask

    initial begin
        reset = 1'b1;
        selected_gate = 8'h00;
        completed_gate = 9'h000;
        current_gate = 8'h00;
        vga_blankout = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.xy", {x, 1'b0, y}, 16'h0000);
        check("reset.ctl", {colour, plot, busy, frame_done}, 6'b000000);

        // Release with all inputs 0: dirty forces an all-white frame
        reset = 1'b0;
        fill_tiles(3'b111);
        run_frame("init");
        idle_quiet("init");

        selected_gate = 8'h04;
        completed_gate = 9'h003;
        fill_tiles(3'b111);
        exp_tile[0] = 3'b010;
        exp_tile[1] = 3'b010;
        exp_tile[2] = 3'b110;
        run_frame("selcomp");

        selected_gate = 8'h01;
        completed_gate = 9'h000;
        vga_blankout = 1'b1;
        fill_tiles(3'b000);
        run_frame("blank");

        vga_blankout = 1'b0;
        fill_tiles(3'b111);
        exp_tile[0] = 3'b110;
        run_frame("unblank");
        idle_quiet("unblank");

        // Mid-frame change must not disturb the frame in progress
        completed_gate = 9'h100;
        exp_tile[8] = 3'b010;
        change_at = 500;
        run_frame("chg1");
        change_at = -1;
        exp_tile[4] = 3'b001;
        run_frame("chg2");
        idle_quiet("chg2");

        // Completed outranks current on the same tile
        completed_gate = 9'h010;
        exp_tile[4] = 3'b010;
        exp_tile[8] = 3'b111;
        run_frame("prio");

        // Abort at pixel 1000 with reset, then expect a full redraw from a clean snapshot
        completed_gate = 9'h000;
        abort_at = 1000;
        run_frame("abort");
        abort_at = -1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold.ctl", {colour, plot, busy, frame_done}, 6'b000000);
        end
        check("rst_hold.xy", {x, 1'b0, y}, 16'h0000);
        reset = 1'b0;
        fill_tiles(3'b111);
        exp_tile[0] = 3'b110;
        exp_tile[4] = 3'b001;
        run_frame("post_rst");
        idle_quiet("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
